// File: rtl/vco_adc_ctrl.sv
// Conversion sequencer for the VCO-based ADC: settle, gate-window edge count, output FIFO.
// Optional feature macro VCO_ADC_CTRL_OFFSET_EN adds cfg_offset (count - offset, floored at 0).
module vco_adc_ctrl #(
  parameter int COUNT_W    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_W   = 8
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_start,
  input  logic                cfg_continuous,
  input  logic                cfg_abort,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [15:0]         cfg_window,
  input  logic                cfg_clr_ovf,
`ifdef VCO_ADC_CTRL_OFFSET_EN
  input  logic [COUNT_W-1:0]  cfg_offset,
`endif
  input  logic                vco_clk_in,
  output logic                vco_en,
  output logic [COUNT_W-1:0]  sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  state_t               state_r, next_state_s;
  logic [SETTLE_W-1:0]  settle_cnt_r;
  logic [15:0]          window_cnt_r;
  logic [COUNT_W-1:0]   edge_cnt_r;
  logic                 sync1_r, sync2_r, prev_r;
  logic                 edge_s;
  logic                 vco_en_r, busy_r, overflow_r;
  logic [COUNT_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr_r, rd_ptr_r;
  logic                 empty_s, full_s, push_s, pop_s, accept_s, drop_s;
  logic                 load_window_s;
  logic [COUNT_W-1:0]   push_data_s;

  assign edge_s        = sync2_r & ~prev_r;
  assign empty_s       = (wr_ptr_r == rd_ptr_r);
  assign full_s        = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                         (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_s         = ~empty_s & sample_ready;
  assign push_s        = (state_r == ST_EMIT) & ~cfg_abort;
  assign accept_s      = push_s & (~full_s | pop_s);
  assign drop_s        = push_s & ~accept_s;
  assign load_window_s = (next_state_s == ST_COUNT) && (state_r != ST_COUNT);

  assign vco_en       = vco_en_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign sample_valid = ~empty_s;
  assign sample_data  = mem_r[rd_ptr_r[PTR_W-1:0]];

  // Sample value handed to the FIFO
  always_comb begin
`ifdef VCO_ADC_CTRL_OFFSET_EN
    if (edge_cnt_r > cfg_offset) begin
      push_data_s = edge_cnt_r - cfg_offset;
    end else begin
      push_data_s = {COUNT_W{1'b0}};
    end
`else
    push_data_s = edge_cnt_r;
`endif
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    next_state_s = state_r;
    if (cfg_abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            next_state_s = (cfg_settle == {SETTLE_W{1'b0}}) ? ST_COUNT : ST_SETTLE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == {{(SETTLE_W-1){1'b0}}, 1'b1}) begin
            next_state_s = ST_COUNT;
          end else begin
            next_state_s = ST_SETTLE;
          end
        end
        ST_COUNT: begin
          if (window_cnt_r == 16'd1) begin
            next_state_s = ST_EMIT;
          end else begin
            next_state_s = ST_COUNT;
          end
        end
        ST_EMIT:  next_state_s = cfg_continuous ? ST_COUNT : ST_IDLE;
        default:  next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register, registered status outputs, VCO synchronizer and counters
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r      <= ST_IDLE;
      vco_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      prev_r       <= 1'b0;
      settle_cnt_r <= {SETTLE_W{1'b0}};
      window_cnt_r <= 16'd0;
      edge_cnt_r   <= {COUNT_W{1'b0}};
    end else begin
      state_r  <= next_state_s;
      vco_en_r <= (next_state_s != ST_IDLE);
      busy_r   <= (next_state_s != ST_IDLE);
      sync1_r  <= vco_clk_in;
      sync2_r  <= sync1_r;
      prev_r   <= sync2_r;
      if (state_r == ST_IDLE) begin
        settle_cnt_r <= cfg_settle;
      end else if (state_r == ST_SETTLE) begin
        settle_cnt_r <= settle_cnt_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
      end else begin
        settle_cnt_r <= settle_cnt_r;
      end
      if (load_window_s) begin
        window_cnt_r <= (cfg_window == 16'd0) ? 16'd1 : cfg_window;
        edge_cnt_r   <= {COUNT_W{1'b0}};
      end else if (state_r == ST_COUNT) begin
        window_cnt_r <= window_cnt_r - 16'd1;
        if (edge_s && !(&edge_cnt_r)) begin
          edge_cnt_r <= edge_cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
          edge_cnt_r <= edge_cnt_r;
        end
      end else begin
        window_cnt_r <= window_cnt_r;
        edge_cnt_r   <= edge_cnt_r;
      end
    end
  end

  // Output FIFO storage, pointers and sticky overflow (set wins over clear)
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {COUNT_W{1'b0}};
      end
      wr_ptr_r   <= {(PTR_W+1){1'b0}};
      rd_ptr_r   <= {(PTR_W+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data_s;
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (cfg_clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

endmodule

// File: tb/tb_vco_adc_ctrl.sv
// Scoreboard bench for vco_adc_ctrl: random per-cycle VCO levels, expected counts from window timing.
module tb_vco_adc_ctrl;
  localparam int CW   = 4;
  localparam int NCYC = 8000;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          resetb, cfg_start, cfg_continuous, cfg_abort, cfg_clr_ovf;
  logic [7:0]    cfg_settle;
  logic [15:0]   cfg_window;
  logic          vco_clk_in, vco_en, sample_valid, sample_ready, busy, overflow;
  logic [CW-1:0] sample_data;
`ifdef VCO_ADC_CTRL_OFFSET_EN
  logic [CW-1:0] cfg_offset;
`endif

  int  checks = 0, failures = 0, cyc = 0, pops = 0;
  bit  vbits [NCYC];
  bit  rand_ready = 1'b0;
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] mon_exp;

  vco_adc_ctrl #(.COUNT_W(CW), .FIFO_DEPTH(4), .SETTLE_W(8)) dut (
    .clock(clock), .resetb(resetb), .cfg_start(cfg_start), .cfg_continuous(cfg_continuous),
    .cfg_abort(cfg_abort), .cfg_settle(cfg_settle), .cfg_window(cfg_window),
    .cfg_clr_ovf(cfg_clr_ovf),
`ifdef VCO_ADC_CTRL_OFFSET_EN
    .cfg_offset(cfg_offset),
`endif
    .vco_clk_in(vco_clk_in), .vco_en(vco_en), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .overflow(overflow));

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    vco_clk_in = (cyc < NCYC) ? vbits[cyc] : 1'b0;
    if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until(input int t);
    int g = 0;
    while (cyc < t && g < 5000) begin
      tick();
      g++;
    end
  endtask

  // A VCO rise held from cycle c is seen as an edge pulse in cycle c+2.
  function automatic int exp_count(input int a, input int b);
    int n = 0;
    for (int c = a - 2; c <= b - 2; c++)
      if (c >= 1 && c < NCYC && vbits[c] && !vbits[c-1]) n++;
    if (n > MAXC) n = MAXC;
`ifdef VCO_ADC_CTRL_OFFSET_EN
    n = (n > int'(cfg_offset)) ? n - int'(cfg_offset) : 0;
`endif
    return n;
  endfunction

  task automatic set_square(input int from, input int len, input int p);
    for (int i = from; i < from + len; i++)
      if (i < NCYC) vbits[i] = ((i - from) % p) < (p / 2);
  endtask

  task automatic start_conv(input int s, input int w, input bit cont, output int a, output int b);
    cfg_settle = 8'(s);
    cfg_window = 16'(w);
    cfg_continuous = cont;
    cfg_start = 1'b1;
    a = cyc + 1 + s;
    b = a + ((w == 0) ? 1 : w) - 1;
    tick();
    cfg_start = 1'b0;
    check("vco_en_rise", vco_en, 1);
    check("busy_rise", busy, 1);
  endtask

  task automatic drain();
    int g = 0;
    rand_ready = 1'b0;
    sample_ready = 1'b1;
    while (exp_q.size() > 0 && g < 300) begin
      tick();
      g++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("fifo_empty", sample_valid, 0);
  endtask

  task automatic single(input int s, input int w, input bit rr);
    int a, b;
    rand_ready = rr;
    if (!rr) sample_ready = 1'b0;
    start_conv(s, w, 1'b0, a, b);
    exp_q.push_back(CW'(exp_count(a, b)));
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_until(b + 1);
    check("busy_in_emit", busy, 1);
    tick();
    check("busy_after_emit", busy, 0);
    check("vco_en_after_emit", vco_en, 0);
    drain();
  endtask

  // Scoreboard monitor: every accepted handshake must match the oldest expected sample
  always @(negedge clock) begin
    if (resetb && sample_valid && sample_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sample_data", sample_data, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int a, b, a0, e4, w, s;
    for (int i = 0; i < NCYC; i++) vbits[i] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 6; i++) vbits[i] = 1'b0;
    resetb = 1'b0; cfg_start = 1'b0; cfg_continuous = 1'b0; cfg_abort = 1'b0;
    cfg_clr_ovf = 1'b0; cfg_settle = 8'd0; cfg_window = 16'd0;
    vco_clk_in = 1'b0; sample_ready = 1'b0;
`ifdef VCO_ADC_CTRL_OFFSET_EN
    cfg_offset = CW'($urandom_range(0, 6));
`endif
    repeat (3) @(posedge clock);
    #1;
    check("rst_vco_en", vco_en, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_data", sample_data, 0);
    resetb = 1'b1;

    // single shot, square VCO of period 4, settle 10, window 100 (saturates)
    set_square(cyc + 1, 300, 4);
    single(10, 100, 1'b0);

    // settle 0, window 0, VCO held low
    for (int i = cyc; i < cyc + 30; i++) vbits[i] = 1'b0;
    single(0, 0, 1'b1);

    // randomized single shots
    repeat (8) single($urandom_range(0, 12), $urandom_range(0, 90), 1'b1);

    // continuous with stalled consumer: 4 stored, 5th dropped
    sample_ready = 1'b0;
    s = $urandom_range(1, 8);
    set_square(cyc + 1, 400, 8);
    start_conv(s, 40, 1'b1, a0, b);
    for (int k = 0; k < 4; k++) exp_q.push_back(CW'(exp_count(a0 + k * 41, a0 + k * 41 + 39)));
    e4 = a0 + 4 * 41 + 40;
    run_until(e4);
    check("ovf_before_drop", overflow, 0);
    tick();
    check("ovf_set", overflow, 1);
    check("head_stable", sample_data, exp_q[0]);
    check("busy_continuous", busy, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_vco_en", vco_en, 0);
    cfg_clr_ovf = 1'b1;
    tick();
    cfg_clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    drain();

    // full FIFO with a pop in the EMIT cycle; continuous cleared mid-window
    sample_ready = 1'b0;
    w = $urandom_range(10, 30);
    start_conv($urandom_range(1, 6), w, 1'b1, a0, b);
    for (int k = 0; k < 5; k++)
      exp_q.push_back(CW'(exp_count(a0 + k * (w + 1), a0 + k * (w + 1) + w - 1)));
    e4 = a0 + 4 * (w + 1) + w;
    run_until(e4 - 5);
    cfg_continuous = 1'b0;
    run_until(e4);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check("no_ovf_with_pop", overflow, 0);
    check("idle_after_last_window", busy, 0);
    drain();

    // abort mid-COUNT discards the partial count
    set_square(cyc + 1, 200, 4);
    start_conv(5, 100, 1'b0, a, b);
    run_until(a + 30);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("abort_cnt_vco_en", vco_en, 0);
    check("abort_cnt_busy", busy, 0);
    sample_ready = 1'b1;
    repeat (10) tick();
    check("no_sample_after_abort", sample_valid, 0);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    check("abort_beats_start", busy, 0);
    single(3, 20, 1'b1);

    // asynchronous reset mid-COUNT with a sample held in the FIFO
    rand_ready = 1'b0;
    sample_ready = 1'b0;
    start_conv(2, 5, 1'b0, a, b);
    run_until(b + 3);
    check("held_sample_valid", sample_valid, 1);
    start_conv(3, 50, 1'b0, a, b);
    run_until(a + 10);
    @(negedge clock);
    resetb = 1'b0;
    #1;
    check("rst_mid_vco_en", vco_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", sample_valid, 0);
    check("rst_mid_overflow", overflow, 0);
    check("rst_mid_data", sample_data, 0);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
